// File: rtl/idelay_cal_pkg.sv
// rtl/idelay_cal_pkg.sv - shared types, widths and helpers for the IDELAY eye calibration
package idelay_cal_pkg;

    localparam int TAP_W = 9;
    localparam int LEN_W = 10;

    typedef logic [TAP_W-1:0] tap_t;
    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_VTC_OFF,
        S_SEEK0,
        S_SETTLE,
        S_SAMPLE,
        S_TRACK,
        S_CENTER,
        S_PARK,
        S_ERROR,
        S_DONE
    } state_t;

    // Phase that SETTLE hands control back to once the tap has been verified.
    typedef enum logic [1:0] {
        RET_SEEK,
        RET_SWEEP,
        RET_PARK
    } ret_t;

    function automatic len_t win_len(input tap_t s, input tap_t e);
        return {1'b0, e} - {1'b0, s};
    endfunction

    function automatic tap_t eye_center(input tap_t s, input tap_t e);
        len_t half;
        half = win_len(s, e) >> 1;
        return s + half[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/idelay_eye_cal_if.sv
// rtl/idelay_eye_cal_if.sv - control/readback bus between calibration FSM and IDELAY capture block
interface idelay_eye_cal_if #(
    parameter int WIDTH = 1
);
    localparam int CNT_W = idelay_cal_pkg::TAP_W * WIDTH;

    logic             idly_en;
    logic             idly_inc;
    logic             idly_en_vtc;
    logic [CNT_W-1:0] idly_cnt_value_out;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;

    modport master (
        output idly_en,
        output idly_inc,
        output idly_en_vtc,
        input  idly_cnt_value_out,
        input  q1,
        input  q2
    );

    modport slave (
        input  idly_en,
        input  idly_inc,
        input  idly_en_vtc,
        output idly_cnt_value_out,
        output q1,
        output q2
    );

endinterface

// File: rtl/idelay_eye_tracker.sv
// rtl/idelay_eye_tracker.sv - tracks open/best passing tap windows during the sweep
module idelay_eye_tracker
    import idelay_cal_pkg::*;
#(
    parameter int TAP_MAX = 511
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic step_i,
    input  logic pass_i,
    input  logic last_i,
    input  tap_t tap_i,
    output tap_t eye_start_o,
    output tap_t eye_end_o,
    output logic valid_o
);

    logic open_q, open_d;
    tap_t cur_q, cur_d;
    tap_t best_s_q, best_s_d;
    tap_t best_e_q, best_e_d;
    logic valid_q, valid_d;

    logic close_w;
    tap_t cs_w, ce_w;

    always_comb begin
        open_d   = open_q;
        cur_d    = cur_q;
        best_s_d = best_s_q;
        best_e_d = best_e_q;
        valid_d  = valid_q;
        close_w  = 1'b0;
        cs_w     = cur_q;
        ce_w     = tap_i;

        if (step_i) begin
            if (pass_i) begin
                if (!open_q) begin
                    cur_d  = tap_i;
                    open_d = 1'b1;
                end
                if (last_i) begin
                    close_w = 1'b1;
                    cs_w    = open_q ? cur_q : tap_i;
                    ce_w    = tap_t'(TAP_MAX);
                    open_d  = 1'b0;
                end
            end else if (open_q) begin
                close_w = 1'b1;
                cs_w    = cur_q;
                ce_w    = tap_i - tap_t'(1);
                open_d  = 1'b0;
            end
        end

        // Strictly longer only, so the lowest window survives a tie.
        if (close_w && (!valid_q || win_len(cs_w, ce_w) > win_len(best_s_q, best_e_q))) begin
            best_s_d = cs_w;
            best_e_d = ce_w;
            valid_d  = 1'b1;
        end

        if (clear_i) begin
            open_d   = 1'b0;
            cur_d    = '0;
            best_s_d = '0;
            best_e_d = '0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q   <= 1'b0;
            cur_q    <= '0;
            best_s_q <= '0;
            best_e_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            open_q   <= open_d;
            cur_q    <= cur_d;
            best_s_q <= best_s_d;
            best_e_q <= best_e_d;
            valid_q  <= valid_d;
        end
    end

    assign eye_start_o = best_s_q;
    assign eye_end_o   = best_e_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/idelay_eye_cal.sv
// rtl/idelay_eye_cal.sv - sweeps the shared IDELAY tap, finds the widest passing eye, parks at its centre
module idelay_eye_cal
    import idelay_cal_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               TAP_MAX       = 511,
    parameter int               VTC_WAIT      = 10,
    parameter int               SETTLE_CYCLES = 8,
    parameter int               SAMPLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] EXP_Q1        = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] EXP_Q2        = {WIDTH{1'b0}}
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start_i,
    output logic      busy_o,
    output logic      done_o,
    output logic      fail_o,
    output tap_t      tap_o,
    output tap_t      eye_start_o,
    output tap_t      eye_end_o,
    idelay_eye_cal_if.master idly
);

    localparam logic [15:0] VTC_LAST    = 16'(VTC_WAIT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);

    state_t      state_q, state_d;
    ret_t        ret_q, ret_d;
    logic [15:0] cnt_q, cnt_d;
    tap_t        tap_q, tap_d;
    tap_t        target_q, target_d;
    logic        pass_q, pass_d;
    logic        ok_q, ok_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic        en_q, en_d;
    logic        inc_q, inc_d;
    logic        vtc_q, vtc_d;

    tap_t readback;
    logic match;
    logic trk_clear;
    logic eye_valid;
    tap_t eye_s, eye_e;

    assign readback  = idly.idly_cnt_value_out[TAP_W-1:0];
    assign match     = (idly.q1 == EXP_Q1) && (idly.q2 == EXP_Q2);
    assign trk_clear = (state_q == S_IDLE) && start_i;

    if (WIDTH > 1) begin : g_unused_lanes
        logic unused_lanes;
        assign unused_lanes = ^idly.idly_cnt_value_out[TAP_W*WIDTH-1:TAP_W];
    end

    idelay_eye_tracker #(
        .TAP_MAX (TAP_MAX)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (trk_clear),
        .step_i      (state_q == S_TRACK),
        .pass_i      (pass_q),
        .last_i      (tap_q == tap_t'(TAP_MAX)),
        .tap_i       (tap_q),
        .eye_start_o (eye_s),
        .eye_end_o   (eye_e),
        .valid_o     (eye_valid)
    );

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cnt_d    = cnt_q;
        tap_d    = tap_q;
        target_d = target_q;
        pass_d   = pass_q;
        ok_d     = ok_q;
        busy_d   = busy_q;
        done_d   = done_q;
        fail_d   = fail_q;
        en_d     = 1'b0;
        inc_d    = inc_q;
        vtc_d    = vtc_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    vtc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_VTC_OFF;
                end
            end
            S_VTC_OFF: begin
                if (cnt_q == VTC_LAST) begin
                    tap_d   = readback;
                    state_d = S_SEEK0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SEEK0: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
                if (tap_q == '0) begin
                    ret_d = RET_SWEEP;
                end else begin
                    en_d  = 1'b1;
                    inc_d = 1'b0;
                    tap_d = tap_q - tap_t'(1);
                    ret_d = RET_SEEK;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (readback != tap_q) begin
                        state_d = S_ERROR;
                    end else begin
                        unique case (ret_q)
                            RET_SEEK:  state_d = S_SEEK0;
                            RET_SWEEP: begin
                                state_d = S_SAMPLE;
                                pass_d  = 1'b1;
                            end
                            default:   state_d = S_PARK;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SAMPLE: begin
                pass_d = pass_q && match;
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = S_TRACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TRACK: begin
                if (tap_q == tap_t'(TAP_MAX)) begin
                    state_d = S_CENTER;
                end else begin
                    en_d    = 1'b1;
                    inc_d   = 1'b1;
                    tap_d   = tap_q + tap_t'(1);
                    cnt_d   = '0;
                    ret_d   = RET_SWEEP;
                    state_d = S_SETTLE;
                end
            end
            S_CENTER: begin
                if (!eye_valid) begin
                    ok_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    target_d = eye_center(eye_s, eye_e);
                    state_d  = S_PARK;
                end
            end
            S_PARK: begin
                // Sweep ends at TAP_MAX, so parking only ever walks downwards.
                if (tap_q == target_q) begin
                    ok_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    en_d    = 1'b1;
                    inc_d   = 1'b0;
                    tap_d   = tap_q - tap_t'(1);
                    cnt_d   = '0;
                    ret_d   = RET_PARK;
                    state_d = S_SETTLE;
                end
            end
            S_ERROR: begin
                ok_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = ok_q;
                fail_d  = !ok_q;
                busy_d  = 1'b0;
                vtc_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ret_q    <= RET_SEEK;
            cnt_q    <= '0;
            tap_q    <= '0;
            target_q <= '0;
            pass_q   <= 1'b0;
            ok_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            en_q     <= 1'b0;
            inc_q    <= 1'b0;
            vtc_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            cnt_q    <= cnt_d;
            tap_q    <= tap_d;
            target_q <= target_d;
            pass_q   <= pass_d;
            ok_q     <= ok_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            en_q     <= en_d;
            inc_q    <= inc_d;
            vtc_q    <= vtc_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign fail_o           = fail_q;
    assign tap_o            = tap_q;
    assign eye_start_o      = eye_s;
    assign eye_end_o        = eye_e;
    assign idly.idly_en     = en_q;
    assign idly.idly_inc    = inc_q;
    assign idly.idly_en_vtc = vtc_q;

endmodule
